// File: rtl/feature_engine_mc_if.sv
// Handshake bundle between the sample source, feature_engine_mc and the classifier.
// The sample stream flows into the engine and the feature stream flows out of it.
interface feature_engine_mc_if #(
    parameter int DATA_W = 16,
    parameter int CH     = 3,
    parameter int FEAT_W = 32
);
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic                   s_valid;
    logic                   s_ready;
    logic [CH*DATA_W-1:0]   s_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [FEAT_W-1:0]      m_data;
    logic [CH_W-1:0]        m_ch;
    logic [2:0]             m_id;

    // Source / sink side: drives samples and accepts feature words.
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_ch, m_id
    );

    // Engine side.
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_ch, m_id
    );
endinterface

// File: rtl/feature_engine_mc.sv
// Multi-channel window feature extractor: per channel mean, range, RMS,
// peak count and largest peak over 2**WIN_LOG2 samples. One restoring
// square-root unit is shared by all channels; results stream out as
// 5*CH words, channel-major.
module feature_engine_mc #(
    parameter int DATA_W   = 16,
    parameter int CH       = 3,
    parameter int WIN_LOG2 = 8,
    parameter int FEAT_W   = 32
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               start,
    feature_engine_mc_if.slave bus,
    output logic               busy,
    output logic [15:0]        win_count
);
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
    localparam int SUM_W  = DATA_W + WIN_LOG2;
    localparam int SQ_W   = 2 * DATA_W + WIN_LOG2;
    localparam int MSQ_W  = 2 * DATA_W;
    localparam int REM_W  = DATA_W + 2;
    localparam int STEP_W = $clog2(DATA_W + 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CH - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DATA_W);
    localparam logic [2:0]        LAST_ID   = 3'd4;

    typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE, OUTPUT} state_t;
    state_t state_q, state_d;

    // Per-channel accumulators and window history.
    logic signed [SUM_W-1:0]  sum_q      [CH];
    logic        [SQ_W-1:0]   sumsq_q    [CH];
    logic signed [DATA_W-1:0] max_q      [CH];
    logic signed [DATA_W-1:0] min_q      [CH];
    logic signed [DATA_W-1:0] p1_q       [CH];
    logic signed [DATA_W-1:0] p2_q       [CH];
    logic signed [DATA_W-1:0] max_peak_q [CH];
    logic [WIN_LOG2-1:0]      peaks_q    [CH];
    logic [DATA_W-1:0]        rms_q      [CH];

    logic signed [DATA_W-1:0] x  [CH];
    logic signed [MSQ_W-1:0]  xe [CH];
    logic        [MSQ_W-1:0]  sq [CH];

    // Control counters and square-root datapath.
    logic [WIN_LOG2-1:0] samp_cnt;
    logic [CH_W-1:0]     comp_ch, out_ch;
    logic [STEP_W-1:0]   comp_step;
    logic [2:0]          out_id;
    logic [MSQ_W-1:0]    rad_q;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   root_q, root_d;
    logic [REM_W+1:0]    rem_shift, trial;
    logic                sq_fit;

    logic signed [DATA_W-1:0] mean_v;
    logic signed [DATA_W:0]   range_v;
    logic [FEAT_W-1:0]        word;
    logic beat, accept, first_beat, hist_ok, last_beat, last_word, sqrt_done;

    assign busy        = (state_q != IDLE);
    assign bus.s_ready = (state_q == ACCUM);
    assign bus.m_valid = (state_q == OUTPUT);
    assign beat        = bus.s_valid && bus.s_ready;
    assign accept      = bus.m_valid && bus.m_ready;
    assign first_beat  = (samp_cnt == '0);
    assign hist_ok     = (samp_cnt > WIN_LOG2'(1));
    assign last_beat   = (samp_cnt == '1);
    assign last_word   = (out_ch == LAST_CH) && (out_id == LAST_ID);
    assign sqrt_done   = (comp_ch == LAST_CH) && (comp_step == LAST_STEP);

    // State register.
    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; dropping start wins over every other transition.
    // NOTE: state_d gets a default first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)                        state_d = ACCUM;
            ACCUM:   if (beat && last_beat)            state_d = COMPUTE;
            COMPUTE: if (sqrt_done)                    state_d = OUTPUT;
            OUTPUT:  if (accept && last_word)          state_d = ACCUM;
            default:                                   state_d = IDLE;
        endcase
        if (!start) state_d = IDLE;
    end

    // Split the beat into per-channel samples and their squares.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            x[c]  = bus.s_data[c*DATA_W +: DATA_W];
            xe[c] = {{DATA_W{x[c][DATA_W-1]}}, x[c]};
            sq[c] = xe[c] * xe[c];
        end
    end

    // Per-channel window statistics; the first beat of a window reloads everything.
    // NOTE: these register arrays are plain flops, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset || !start) begin
            for (int c = 0; c < CH; c++) begin
                sum_q[c]  <= '0; sumsq_q[c] <= '0; max_q[c]   <= '0; min_q[c]      <= '0;
                p1_q[c]   <= '0; p2_q[c]    <= '0; peaks_q[c] <= '0; max_peak_q[c] <= '0;
            end
        end else if (beat) begin
            for (int c = 0; c < CH; c++) begin
                p1_q[c] <= x[c];
                p2_q[c] <= first_beat ? '0 : p1_q[c];
                if (first_beat) begin
                    sum_q[c]      <= {{WIN_LOG2{x[c][DATA_W-1]}}, x[c]};
                    sumsq_q[c]    <= {{WIN_LOG2{1'b0}}, sq[c]};
                    max_q[c]      <= x[c];
                    min_q[c]      <= x[c];
                    peaks_q[c]    <= '0;
                    max_peak_q[c] <= '0;
                end else begin
                    sum_q[c]   <= sum_q[c] + {{WIN_LOG2{x[c][DATA_W-1]}}, x[c]};
                    sumsq_q[c] <= sumsq_q[c] + {{WIN_LOG2{1'b0}}, sq[c]};
                    if (x[c] > max_q[c]) max_q[c] <= x[c];
                    if (x[c] < min_q[c]) min_q[c] <= x[c];
                    if (hist_ok && (p1_q[c] > p2_q[c]) && (x[c] < p1_q[c])) begin
                        peaks_q[c] <= peaks_q[c] + 1'b1;
                        if ((peaks_q[c] == '0) || (p1_q[c] > max_peak_q[c])) max_peak_q[c] <= p1_q[c];
                    end
                end
            end
        end
    end

    // One restoring square-root step: bring down two radicand bits, try root*4+1.
    always_comb begin
        rem_shift = {rem_q, rad_q[MSQ_W-1 -: 2]};
        trial     = {2'b00, root_q, 2'b01};
        sq_fit    = (rem_shift >= trial);
        rem_d     = sq_fit ? REM_W'(rem_shift - trial) : REM_W'(rem_shift);
        root_d    = {root_q[DATA_W-2:0], sq_fit};
    end

    // Beat counter, COMPUTE sequencing per channel, OUTPUT word pointer and window count.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset || !start) begin
            samp_cnt <= '0; comp_ch <= '0; comp_step <= '0; out_ch <= '0; out_id <= '0;
            win_count <= '0; rad_q <= '0; rem_q <= '0; root_q <= '0;
            for (int c = 0; c < CH; c++) rms_q[c] <= '0;
        end else begin
            if (beat) samp_cnt <= samp_cnt + 1'b1;
            if (state_q == COMPUTE) begin
                if (comp_step == '0) begin
                    rad_q  <= MSQ_W'(sumsq_q[comp_ch] >> WIN_LOG2);
                    rem_q  <= '0;
                    root_q <= '0;
                end else begin
                    rad_q  <= rad_q << 2;
                    rem_q  <= rem_d;
                    root_q <= root_d;
                end
                if (comp_step == LAST_STEP) begin
                    rms_q[comp_ch] <= root_d;
                    comp_step      <= '0;
                    comp_ch        <= (comp_ch == LAST_CH) ? '0 : comp_ch + 1'b1;
                end else begin
                    comp_step <= comp_step + 1'b1;
                end
            end
            if (accept) begin
                if (out_id == LAST_ID) begin
                    out_id <= '0;
                    out_ch <= (out_ch == LAST_CH) ? '0 : out_ch + 1'b1;
                end else begin
                    out_id <= out_id + 1'b1;
                end
                if (last_word) win_count <= win_count + 1'b1;
            end
        end
    end

    // Feature word mux; the pointer only moves on acceptance, so the word holds under back-pressure.
    always_comb begin
        mean_v  = sum_q[out_ch][WIN_LOG2 +: DATA_W];
        range_v = {max_q[out_ch][DATA_W-1], max_q[out_ch]} - {min_q[out_ch][DATA_W-1], min_q[out_ch]};
        word    = '0;
        case (out_id)
            3'd0:    word = {{(FEAT_W-DATA_W){mean_v[DATA_W-1]}}, mean_v};
            3'd1:    word = {{(FEAT_W-DATA_W-1){range_v[DATA_W]}}, range_v};
            3'd2:    word = {{(FEAT_W-DATA_W){1'b0}}, rms_q[out_ch]};
            3'd3:    word = {{(FEAT_W-WIN_LOG2){1'b0}}, peaks_q[out_ch]};
            3'd4:    word = {{(FEAT_W-DATA_W){max_peak_q[out_ch][DATA_W-1]}}, max_peak_q[out_ch]};
            default: word = '0;
        endcase
        bus.m_data = bus.m_valid ? word   : '0;
        bus.m_ch   = bus.m_valid ? out_ch : '0;
        bus.m_id   = bus.m_valid ? out_id : '0;
    end
endmodule

// File: tb/tb_feature_engine_mc.sv
// Scoreboard bench for feature_engine_mc (CH=2, WIN_LOG2=3): a reference model
// pushes expected words when a window is driven; a monitor pops them on each
// accepted output word.
`timescale 1ns/1ps
module tb_feature_engine_mc;
    localparam int DATA_W = 16, CH = 2, WIN_LOG2 = 3, FEAT_W = 32, WIN = 8;

    typedef int win_t [WIN];
    typedef struct { int ch; int id; longint data; } exp_t;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic [15:0] win_count;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   accept_cyc = 0;
    exp_t sb [$];
    exp_t mon_e;

    win_t w_mixed = '{1, 3, 2, 5, 4, 4, 6, 1};
    win_t w_const = '{WIN{-4}};
    win_t w_floor = '{-1, -1, -1, -2, -1, -1, -1, -1};
    win_t w_neg   = '{-10, -5, -9, -20, -15, -30, -40, -50};
    win_t w_alt   = '{-5, -3, -7, -1, -2, -8, 4, -6};
    win_t w_min   = '{WIN{-32768}};
    win_t w_max   = '{WIN{32767}};
    win_t w_a     = '{0, 2, 1, 3, 4, 5, 6, 5};
    win_t w_b     = '{1, 3, 2, 2, 0, -1, 5, 7};
    win_t w_c     = '{1, 0, 0, 0, 0, 0, 0, 0};

    feature_engine_mc_if #(.DATA_W(DATA_W), .CH(CH), .FEAT_W(FEAT_W)) bus_if ();

    feature_engine_mc #(
        .DATA_W(DATA_W), .CH(CH), .WIN_LOG2(WIN_LOG2), .FEAT_W(FEAT_W)
    ) dut (
        .clk(clk),
        .nReset(nReset),
        .start(start),
        .bus(bus_if),
        .busy(busy),
        .win_count(win_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: direct definitions, integer sqrt by search.
    function automatic void model_window(input int ch, input win_t s);
        longint sum = 0, sumsq = 0, msq, r = 0;
        int mx = s[0], mn = s[0], pk = 0, mp = 0;
        exp_t e;
        for (int i = 0; i < WIN; i++) begin
            sum   += s[i];
            sumsq += longint'(s[i]) * longint'(s[i]);
            if (s[i] > mx) mx = s[i];
            if (s[i] < mn) mn = s[i];
        end
        for (int i = 1; i < WIN - 1; i++) begin
            if (s[i] > s[i-1] && s[i+1] < s[i]) begin
                mp = (pk == 0 || s[i] > mp) ? s[i] : mp;
                pk++;
            end
        end
        msq = sumsq >>> WIN_LOG2;
        while ((r + 1) * (r + 1) <= msq) r++;
        e.ch = ch;
        e.id = 0; e.data = sum >>> WIN_LOG2; sb.push_back(e);
        e.id = 1; e.data = mx - mn;           sb.push_back(e);
        e.id = 2; e.data = r;                 sb.push_back(e);
        e.id = 3; e.data = pk;                sb.push_back(e);
        e.id = 4; e.data = mp;                sb.push_back(e);
    endfunction

    task automatic send_beat(input int a, input int b);
        int guard = 0;
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = {16'(b), 16'(a)};
        @(negedge clk);
        while (!bus_if.s_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("s_ready_timeout", guard, 0);
        @(posedge clk);
        #1;
        accept_cyc     = cyc;
        bus_if.s_valid = 1'b0;
    endtask

    task automatic send_window(input win_t a, input win_t b);
        model_window(0, a);
        model_window(1, b);
        for (int i = 0; i < WIN; i++) send_beat(a[i], b[i]);
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!bus_if.m_valid && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 200) check("m_valid_timeout", waited, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || bus_if.m_valid) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic pulse_start_low();
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
    endtask

    // Monitor: compare each word in the cycle it is accepted.
    always @(negedge clk) begin
        if (bus_if.m_valid && bus_if.m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", bus_if.m_id, -1);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("data_ch%0d_id%0d", mon_e.ch, mon_e.id), $signed(bus_if.m_data), mon_e.data);
                check($sformatf("m_ch_ch%0d_id%0d", mon_e.ch, mon_e.id), bus_if.m_ch, mon_e.ch);
                check($sformatf("m_id_ch%0d_id%0d", mon_e.ch, mon_e.id), bus_if.m_id, mon_e.id);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = '0;
        bus_if.m_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", bus_if.s_ready, 0);
        check("rst_m_valid", bus_if.m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_m_data", bus_if.m_data, 0);
        check("rst_m_ch", bus_if.m_ch, 0);
        check("rst_m_id", bus_if.m_id, 0);
        check("rst_win_count", win_count, 0);
        nReset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        start = 1'b1;

        // Mixed window and COMPUTE latency.
        send_window(w_mixed, w_const);
        wait_valid(waited);
        check("first_valid_latency", cyc - accept_cyc, 34);
        drain();
        check("win_count_1", win_count, 1);

        // Floor mean, negative max_peak, rising signed peaks.
        send_window(w_floor, w_neg);
        drain();
        send_window(w_alt, w_floor);
        drain();
        check("win_count_3", win_count, 3);

        // Back-pressure: word held stable, no beats accepted.
        bus_if.m_ready = 1'b0;
        send_window(w_mixed, w_const);
        wait_valid(waited);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_m_data", $signed(bus_if.m_data), 3);
            check("bp_m_ch", bus_if.m_ch, 0);
            check("bp_m_id", bus_if.m_id, 0);
            check("bp_s_ready", bus_if.s_ready, 0);
            @(posedge clk);
            #1;
        end
        bus_if.m_ready = 1'b1;
        waited = 0;
        while (bus_if.m_valid && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("bp_drain_cycles", waited, 10);
        check("win_count_4", win_count, 4);

        // Abort mid-window, then restart with the mixed window.
        for (int i = 0; i < 4; i++) send_beat(w_a[i], w_b[i]);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_s_ready", bus_if.s_ready, 0);
        check("abort_m_valid", bus_if.m_valid, 0);
        check("abort_win_count", win_count, 0);
        start = 1'b1;
        send_window(w_mixed, w_const);
        drain();
        check("restart_win_count", win_count, 1);

        // Extremes.
        send_window(w_min, w_max);
        drain();
        check("extreme_win_count", win_count, 2);

        // Back-to-back windows; no peak may straddle a window boundary.
        pulse_start_low();
        check("b2b_clear", win_count, 0);
        send_window(w_a, w_alt);
        send_window(w_b, w_const);
        drain();
        check("b2b_win_count", win_count, 2);
        send_window(w_b, w_neg);
        send_window(w_c, w_mixed);
        drain();
        check("b2b_win_count_4", win_count, 4);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/feature_engine_mc.md
Name: feature_engine_mc

Overview:
- Parametrised, multi-channel successor to the single-channel feature extractor.
- Accumulates fixed-length windows of signed samples on CH parallel channels.
- Per channel it computes mean, range (max-min), RMS (shared iterative integer square root), peak count and maximum peak magnitude.
- Results stream out over a valid/ready interface to the classifier. Runs back-to-back windows while start is high.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- CH, 3, number of channels sampled in lock-step.
- WIN_LOG2, 8, window length = 2**WIN_LOG2 samples.
- FEAT_W, 32, output feature width; must be >= 2*DATA_W.

Ports:
- clk, input, 1, clock.
- nReset, input, 1, asynchronous active-low reset.
- start, input, 1, enable; low = synchronous abort/clear.
- s_valid, input, 1, sample beat valid.
- s_ready, output, 1, engine accepts a beat.
- s_data, input, CH*DATA_W, channel c at bits [c*DATA_W +: DATA_W].
- m_valid, output, 1, feature word valid.
- m_ready, input, 1, downstream accepts the feature word.
- m_data, output, FEAT_W, feature value, sign-extended.
- m_ch, output, max(1,$clog2(CH)), channel index of m_data.
- m_id, output, 3, feature id: 0 mean, 1 range, 2 rms, 3 peaks, 4 max_peak.
- busy, output, 1, high whenever state != IDLE.
- win_count, output, 16, completed windows since start rose; wraps at 16 bits.

Behaviour:
- Reset (nReset low, async): state IDLE; s_ready, m_valid, busy = 0; m_data, m_ch, m_id, win_count = 0; all accumulators cleared.
- Clock/reset: clk; reset nReset, asynchronous, active-low.
- FSM: IDLE -> ACCUM on start=1. ACCUM -> COMPUTE after 2**WIN_LOG2 accepted beats. COMPUTE -> OUTPUT after the sqrt for channel CH-1 completes. OUTPUT -> ACCUM after the last word is accepted, if start=1. Any state -> IDLE on the clock edge where start=0.
- Abort (start=0): clears accumulators, sample counter, history, m_valid and win_count the next cycle. No partial results are emitted.
- s_ready = 1 only in ACCUM. A beat is accepted when s_valid&&s_ready.
- Per accepted beat, per channel:
  - sum += x (width DATA_W+WIN_LOG2, signed).
  - sumsq += x*x (width 2*DATA_W+WIN_LOG2, unsigned).
  - Running max/min; the first beat of a window loads both.
- Peak detection uses history p2, p1 (previous two samples in the window). A peak at p1 requires p1 > p2 and x < p1, strictly.
  - On a peak: peaks++ (width WIN_LOG2); max_peak = first peak ? p1 : max(max_peak, p1).
  - Plateaus are never peaks. History clears at window start, so the first detection is possible on beat 3 and peaks never span windows. max_peak = 0 if peaks == 0.
- COMPUTE, per channel, channels 0..CH-1 sequentially:
  - 1 load cycle: mean = sum >>> WIN_LOG2 (arithmetic, floor); msq = sumsq >> WIN_LOG2 (2*DATA_W bits).
  - Then DATA_W restoring square-root iterations, 1 result bit per cycle: rms = floor(sqrt(msq)), DATA_W bits unsigned.
  - COMPUTE lasts exactly CH*(DATA_W+1) cycles.
- OUTPUT order is channel-major, id-minor: (ch0,id0..4), (ch1,id0..4), ... — 5*CH words.
  - The first m_valid appears in the cycle after COMPUTE ends.
  - m_data/m_ch/m_id are held stable while m_valid && !m_ready. The next word is presented the cycle after acceptance, so full throughput is 1 word/clk with m_ready held high.
- Sign extension: mean and range are sign-extended to FEAT_W; rms, peaks and max_peak are zero/sign-extended per their type (max_peak signed).
- win_count increments on acceptance of the last word of a window.
- No beats are accepted in COMPUTE/OUTPUT; upstream must buffer.

Test Plan:
Settings for all tests: CH=2, WIN_LOG2=3, DATA_W=16, FEAT_W=32.
- Mixed window: ch0 = 1,3,2,5,4,4,6,1; ch1 = constant -4.
  - Expected words in order: ch0 {3,5,3,3,6}, ch1 {-4,0,4,0,0}.
  - win_count = 1.
  - First m_valid exactly 34 cycles after the 8th beat is accepted.
- Floor mean: ch0 = seven -1 and one -2 (sum -9) -> mean -2, range 1, rms 1 (msq 11>>3 = 1), peaks 0.
- Back-pressure: hold m_ready=0 for 5 cycles after the first m_valid.
  - m_data=3, m_ch=0, m_id=0 stay stable; s_ready=0 throughout.
  - Release -> remaining 9 words in 9 cycles.
- Abort: drop start after 4 beats -> next cycle busy=0, s_ready=0, win_count=0. Restart with the mixed window -> identical results to the first test.
- Extremes: all samples -32768 -> mean -32768, range 0, rms 32768, peaks 0. No overflow in sumsq (2**33).
- Back-to-back windows: the second window starts 1,3 with the previous window ending 6,5.
  - No cross-window peak is counted.
  - win_count = 2 after both windows are drained.
